// File: rtl/inst_axi_bridge_pkg.sv
// Shared AXI constants, bridge state encoding and response helper for inst_axi_bridge.
package inst_axi_bridge_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;

    typedef enum logic [1:0] {
        IBR_IDLE = 2'd0,
        IBR_AR   = 2'd1,
        IBR_R    = 2'd2,
        IBR_RSP  = 2'd3
    } ibr_state_e;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/inst_axi_bridge.sv
// SRAM-like instruction fetch port to AXI4 AR/R bridge, one outstanding read.
// Optional IBRIDGE_RDATA_REG_EN registers the R beat and answers one cycle later.
module inst_axi_bridge
    import inst_axi_bridge_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_sram_en,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    output logic        inst_rerr,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    ibr_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        ar_hs;
    logic        r_hs;

    // Single outstanding read: transaction ID and last flag carry no information.
    logic unused_ok;
    assign unused_ok = ^{rid, rlast};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IBR_IDLE;
            addr_q  <= 32'd0;
            size_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IBR_IDLE: if (inst_sram_en) state_d = IBR_AR;
            IBR_AR:   if (arready)      state_d = IBR_R;
            IBR_R: begin
                if (rvalid) begin
`ifdef IBRIDGE_RDATA_REG_EN
                    state_d = IBR_RSP;
`else
                    state_d = IBR_IDLE;
`endif
                end
            end
            default:  state_d = IBR_IDLE;
        endcase
    end

    // Request is only sampled in IDLE, so the fetch stage may move addr afterwards.
    always_comb begin
        addr_d = addr_q;
        size_d = size_q;
        if (state_q == IBR_IDLE && inst_sram_en) begin
            addr_d = inst_sram_addr;
            size_d = inst_sram_size;
        end
    end

`ifdef IBRIDGE_RDATA_REG_EN
    logic [31:0] rdata_q, rdata_d;
    logic        rerr_q, rerr_d;

    always_comb begin
        rdata_d = rdata_q;
        rerr_d  = rerr_q;
        if (r_hs) begin
            rdata_d = rdata;
            rerr_d  = resp_is_err(rresp);
        end
    end

    // Data holding registers need no reset; their outputs are gated by RSP.
    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
        rerr_q  <= rerr_d;
    end
`endif

    always_comb begin
        arvalid           = (state_q == IBR_AR);
        rready            = (state_q == IBR_R);
        ar_hs             = (state_q == IBR_AR) && arready;
        r_hs              = (state_q == IBR_R) && rvalid;
        inst_sram_addr_ok = ar_hs;
`ifdef IBRIDGE_RDATA_REG_EN
        inst_sram_data_ok = (state_q == IBR_RSP);
        inst_sram_rdata   = (state_q == IBR_RSP) ? rdata_q : 32'd0;
        inst_rerr         = (state_q == IBR_RSP) && rerr_q;
`else
        inst_sram_data_ok = r_hs;
        inst_sram_rdata   = r_hs ? rdata : 32'd0;
        inst_rerr         = r_hs && resp_is_err(rresp);
`endif
    end

    assign arid    = AXI_ID;
    assign araddr  = addr_q;
    assign arsize  = {1'b0, size_q};
    assign arlen   = 8'd0;
    assign arburst = AXI_BURST_INCR;
    assign arlock  = 2'd0;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;

endmodule

// File: tb/tb_inst_axi_bridge.sv
// Self-checking bench for inst_axi_bridge with a scoreboard of expected read responses.
module tb_inst_axi_bridge;

    logic        clk;
    logic        resetn;
    logic        inst_sram_en;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        inst_rerr;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    int total = 0;
    int bad   = 0;
    logic [32:0] exp_q[$];
    logic overlap;

    inst_axi_bridge #(.AXI_ID(4'd5)) dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_en(inst_sram_en), .inst_sram_size(inst_sram_size),
        .inst_sram_addr(inst_sram_addr), .inst_sram_addr_ok(inst_sram_addr_ok),
        .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
        .inst_rerr(inst_rerr),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (arvalid && rready) overlap <= 1'b1;

    task automatic tick;
        @(posedge clk); #1;
    endtask

    // Drives one R beat while the bridge sits in R and records what the fetch side saw.
    task automatic r_beat(input logic [31:0] d, input logic [1:0] rsp,
                          output logic rdy, output logic dok0, output logic dok,
                          output logic [31:0] dat, output logic err);
        rvalid = 1'b1; rdata = d; rresp = rsp; rid = 4'($urandom); rlast = 1'b1;
        exp_q.push_back({rsp != 2'b00, d});
        @(negedge clk);
        rdy = rready; dok0 = inst_sram_data_ok; dok = dok0;
        dat = inst_sram_rdata; err = inst_rerr;
        tick;
        rvalid = 1'b0; rdata = $urandom; rresp = 2'b00;
`ifdef IBRIDGE_RDATA_REG_EN
        @(negedge clk);
        dok = inst_sram_data_ok; dat = inst_sram_rdata; err = inst_rerr;
        tick;
`endif
    endtask

    task automatic pop_exp(output logic [32:0] e);
        if (exp_q.size() == 0) e = 33'h1_ffff_ffff;
        else e = exp_q.pop_front();
    endtask

    task automatic check_beat(input string nm, input logic rdy, input logic dok0,
                              input logic dok, input logic [31:0] dat, input logic err);
        logic [32:0] e;
        pop_exp(e);
        total++; if (rdy !== 1'b1) begin bad++; $display("FAIL %s_rready got=%b want=1", nm, rdy); end
        total++; if (dok !== 1'b1) begin bad++; $display("FAIL %s_data_ok got=%b want=1", nm, dok); end
        total++; if (dat !== e[31:0]) begin bad++; $display("FAIL %s_rdata got=%h want=%h", nm, dat, e[31:0]); end
        total++; if (err !== e[32]) begin bad++; $display("FAIL %s_rerr got=%b want=%b", nm, err, e[32]); end
`ifdef IBRIDGE_RDATA_REG_EN
        total++; if (dok0 !== 1'b0) begin bad++; $display("FAIL %s_early_data_ok got=%b want=0", nm, dok0); end
`else
        total++; if (dok0 !== dok) begin bad++; $display("FAIL %s_data_ok_same_cycle got=%b want=%b", nm, dok0, dok); end
`endif
    endtask

    task automatic test_reset;
        resetn = 1'b0; inst_sram_en = 1'b1; inst_sram_size = 2'b10; inst_sram_addr = 32'hbfc00000;
        arready = 1'b1; rvalid = 1'b1; rdata = 32'hffffffff; rresp = 2'b10; rid = 4'd0; rlast = 1'b1;
        repeat (3) @(negedge clk);
        total++; if ({arvalid, rready, inst_sram_addr_ok, inst_sram_data_ok, inst_rerr} !== 5'b0) begin
            bad++; $display("FAIL rst_ctrl got=%b want=00000", {arvalid, rready, inst_sram_addr_ok, inst_sram_data_ok, inst_rerr}); end
        total++; if (inst_sram_rdata !== 32'd0) begin bad++; $display("FAIL rst_rdata got=%h want=0", inst_sram_rdata); end
        total++; if (araddr !== 32'd0) begin bad++; $display("FAIL rst_araddr got=%h want=0", araddr); end
        inst_sram_en = 1'b0; rvalid = 1'b0; rdata = 32'd0; rresp = 2'b00;
        tick; resetn = 1'b1;
        @(negedge clk);
        total++; if (arvalid !== 1'b0) begin bad++; $display("FAIL rst_idle_arvalid got=%b want=0", arvalid); end
        tick;
    endtask

    task automatic test_zero_wait;
        logic rdy, dok0, dok, err; logic [31:0] dat;
        inst_sram_en = 1'b1; inst_sram_addr = 32'hbfc00000; inst_sram_size = 2'b10; arready = 1'b1;
        @(negedge clk);
        total++; if (arvalid !== 1'b0) begin bad++; $display("FAIL zw_c0_arvalid got=%b want=0", arvalid); end
        tick; inst_sram_en = 1'b0; inst_sram_addr = 32'h0;
        @(negedge clk);
        total++; if (arvalid !== 1'b1) begin bad++; $display("FAIL zw_arvalid got=%b want=1", arvalid); end
        total++; if (inst_sram_addr_ok !== 1'b1) begin bad++; $display("FAIL zw_addr_ok got=%b want=1", inst_sram_addr_ok); end
        total++; if (araddr !== 32'hbfc00000) begin bad++; $display("FAIL zw_araddr got=%h want=bfc00000", araddr); end
        total++; if (arsize !== 3'b010) begin bad++; $display("FAIL zw_arsize got=%b want=010", arsize); end
        total++; if ({arlen, arburst, arlock, arcache, arprot} !== {8'd0, 2'b01, 2'd0, 4'd0, 3'd0}) begin
            bad++; $display("FAIL zw_fixed got=%h want=%h", {arlen, arburst, arlock, arcache, arprot}, {8'd0, 2'b01, 2'd0, 4'd0, 3'd0}); end
        total++; if (arid !== 4'd5) begin bad++; $display("FAIL zw_arid got=%h want=5", arid); end
        tick;
        r_beat(32'h3c1d0001, 2'b00, rdy, dok0, dok, dat, err);
        check_beat("zw", rdy, dok0, dok, dat, err);
        @(negedge clk);
        total++; if ({arvalid, rready, inst_sram_data_ok} !== 3'b000) begin
            bad++; $display("FAIL zw_back_idle got=%b want=000", {arvalid, rready, inst_sram_data_ok}); end
        tick;
    endtask

    task automatic test_ar_backpressure;
        logic rdy, dok0, dok, err; logic [31:0] dat;
        arready = 1'b0; inst_sram_en = 1'b1; inst_sram_addr = 32'hbfc00004;
        tick; inst_sram_en = 1'b0; inst_sram_addr = 32'h12345678;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if ({arvalid, inst_sram_addr_ok, araddr} !== {1'b1, 1'b0, 32'hbfc00004}) begin
                bad++; $display("FAIL arbp_hold%0d got=%b/%b/%h want=1/0/bfc00004", i, arvalid, inst_sram_addr_ok, araddr); end
            tick;
        end
        arready = 1'b1;
        @(negedge clk);
        total++; if ({inst_sram_addr_ok, araddr} !== {1'b1, 32'hbfc00004}) begin
            bad++; $display("FAIL arbp_hs got=%b/%h want=1/bfc00004", inst_sram_addr_ok, araddr); end
        tick;
        r_beat(32'h11112222, 2'b00, rdy, dok0, dok, dat, err);
        check_beat("arbp", rdy, dok0, dok, dat, err);
    endtask

    task automatic test_r_stall;
        logic rdy, dok0, dok, err; logic [31:0] dat;
        inst_sram_en = 1'b1; inst_sram_addr = 32'hbfc00008;
        tick; inst_sram_en = 1'b0;
        tick;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            total++; if ({rready, inst_sram_data_ok, arvalid} !== 3'b100) begin
                bad++; $display("FAIL rst_stall%0d got=%b want=100", i, {rready, inst_sram_data_ok, arvalid}); end
            tick;
        end
        r_beat(32'h8fbf0010, 2'b00, rdy, dok0, dok, dat, err);
        check_beat("rstall", rdy, dok0, dok, dat, err);
        @(negedge clk);
        total++; if (inst_sram_data_ok !== 1'b0) begin bad++; $display("FAIL rstall_one_pulse got=%b want=0", inst_sram_data_ok); end
        tick;
    endtask

    task automatic test_error_resp;
        logic rdy, dok0, dok, err; logic [31:0] dat;
        logic [1:0] rsps [3] = '{2'b10, 2'b11, 2'b00};
        for (int k = 0; k < 3; k++) begin
            inst_sram_en = 1'b1; inst_sram_addr = 32'hbfc00010 + 32'(k * 4);
            tick; inst_sram_en = 1'b0;
            tick;
            r_beat(32'hdead0000 + 32'(k), rsps[k], rdy, dok0, dok, dat, err);
            check_beat("err", rdy, dok0, dok, dat, err);
        end
    endtask

    task automatic test_back_to_back;
        logic rdy, dok0, dok, err; logic [31:0] dat;
        int n_aok, n_dok;
        n_aok = 0; n_dok = 0; overlap = 1'b0;
        inst_sram_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            inst_sram_addr = 32'hbfc00100 + 32'(k * 4);
            tick;
            @(negedge clk);
            if (inst_sram_addr_ok) n_aok++;
            total++; if (araddr !== 32'hbfc00100 + 32'(k * 4)) begin
                bad++; $display("FAIL b2b_araddr%0d got=%h want=%h", k, araddr, 32'hbfc00100 + 32'(k * 4)); end
            tick;
            r_beat(32'h24000000 + 32'(k), 2'b00, rdy, dok0, dok, dat, err);
            if (dok) n_dok++;
            check_beat("b2b", rdy, dok0, dok, dat, err);
        end
        inst_sram_en = 1'b0;
        @(negedge clk);
        total++; if (n_aok !== 3) begin bad++; $display("FAIL b2b_addr_ok_cnt got=%0d want=3", n_aok); end
        total++; if (n_dok !== 3) begin bad++; $display("FAIL b2b_data_ok_cnt got=%0d want=3", n_dok); end
        total++; if (overlap !== 1'b0) begin bad++; $display("FAIL b2b_ar_r_overlap got=%b want=0", overlap); end
        tick;
    endtask

    task automatic test_reset_mid_r;
        logic rdy, dok0, dok, err; logic [31:0] dat;
        inst_sram_en = 1'b1; inst_sram_addr = 32'hbfc00020;
        tick; inst_sram_en = 1'b0;
        tick;
        @(negedge clk);
        total++; if (rready !== 1'b1) begin bad++; $display("FAIL rmid_in_r got=%b want=1", rready); end
        #2; rvalid = 1'b1; rdata = 32'hcafef00d; resetn = 1'b0;
        #1;
        total++; if ({rready, arvalid, inst_sram_data_ok} !== 3'b000) begin
            bad++; $display("FAIL rmid_async got=%b want=000", {rready, arvalid, inst_sram_data_ok}); end
        total++; if (inst_sram_rdata !== 32'd0) begin bad++; $display("FAIL rmid_rdata got=%h want=0", inst_sram_rdata); end
        rvalid = 1'b0; rdata = 32'd0;
        tick; resetn = 1'b1;
        inst_sram_en = 1'b1; inst_sram_addr = 32'hbfc00040;
        tick; inst_sram_en = 1'b0;
        @(negedge clk);
        total++; if ({arvalid, inst_sram_addr_ok, araddr} !== {1'b1, 1'b1, 32'hbfc00040}) begin
            bad++; $display("FAIL rmid_fresh_ar got=%b/%b/%h want=1/1/bfc00040", arvalid, inst_sram_addr_ok, araddr); end
        tick;
        r_beat(32'h0bf00040, 2'b00, rdy, dok0, dok, dat, err);
        check_beat("rmid", rdy, dok0, dok, dat, err);
    endtask

    initial begin
        overlap = 1'b0;
        test_reset;
        test_zero_wait;
        test_ar_backpressure;
        test_r_stall;
        test_error_resp;
        test_back_to_back;
        test_reset_mid_r;
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
